// File: rtl/ym_dac_stream_gen_if.sv
// Host sample-write port of the DAC stream generator.
// The host (master) drives channel, data and valid; the generator (slave) drives ready.
interface ym_dac_stream_gen_if #(
    parameter int SAMPLE_W = 18
) ();
    logic                sample_valid;
    logic [2:0]          sample_ch;
    logic [SAMPLE_W-1:0] sample_data;
    logic                sample_ready;

    modport master (
        output sample_valid,
        output sample_ch,
        output sample_data,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample_ch,
        input  sample_data,
        output sample_ready
    );
endinterface

// File: rtl/ym_dac_stream_gen.sv
// YMF262-style serial DAC stream generator: bit clock, per-channel sample
// strobes and MSB-first data, fed from double-buffered per-channel holds.
// All stream state moves on the clk edge where ym_dclk falls, so data and
// strobes are stable around the following ym_dclk rising edge.
module ym_dac_stream_gen #(
    parameter int CLK_DIV  = 8,
    parameter int CHANNELS = 2,
    parameter int SAMPLE_W = 18,
    parameter int SLOT_LEN = 18,
    parameter int SMP_ON   = 8,
    parameter int SMP_OFF  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    ym_dac_stream_gen_if.slave  host,
    output logic                ym_dclk,
    output logic [CHANNELS-1:0] ym_smp,
    output logic                ym_data,
    output logic                frame_start,
    output logic                underrun,
    output logic [7:0]          underrun_cnt
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(SLOT_LEN + 1);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    // Set while no tick has happened since reset or en=0: the next tick is
    // the load of channel 0 rather than a counter increment.
    logic                idle_q, idle_d;
    logic                tick;
    logic                load;
    logic                ready_q;
    logic [SAMPLE_W-1:0] shift_q;
    logic                dclk_q;
    logic [CHANNELS-1:0] smp_q, smp_d;
    logic                frame_q;
    logic                under_q;
    logic [7:0]          cnt_q;
    logic [SAMPLE_W-1:0] hold_q  [CHANNELS];
    logic                fresh_q [CHANNELS];
    logic [CHANNELS-1:0] wr_hit;
    logic [SAMPLE_W-1:0] load_word;
    logic                load_fresh;
    logic                load_wr;
    logic                load_stale;

    assign tick = en && (div_q == DIV_W'(CLK_DIV - 1));

    // Divider and slot/channel counters; en=0 parks everything at frame start.
    always_comb begin
        div_d  = div_q;
        bit_d  = bit_q;
        ch_d   = ch_q;
        idle_d = idle_q;
        load   = 1'b0;
        if (!en) begin
            div_d  = '0;
            bit_d  = '0;
            ch_d   = '0;
            idle_d = 1'b1;
        end else begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (tick) begin
                if (idle_q) begin
                    bit_d  = '0;
                    ch_d   = '0;
                    idle_d = 1'b0;
                    load   = 1'b1;
                end else if (bit_q == BIT_W'(SLOT_LEN - 1)) begin
                    bit_d = '0;
                    load  = 1'b1;
                    ch_d  = (ch_q == CH_W'(CHANNELS - 1)) ? '0 : ch_q + CH_W'(1);
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                end
            end
        end
    end

    // Per-channel hold buffers and freshness flags.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            assign wr_hit[gi] = host.sample_valid && ready_q && (host.sample_ch == 3'(gi));

            // Host write fills the hold; a load of this channel consumes it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_q[gi]  <= '0;
                    fresh_q[gi] <= 1'b0;
                end else begin
                    if (wr_hit[gi]) begin
                        hold_q[gi] <= host.sample_data;
                    end
                    if (load && (ch_d == CH_W'(gi))) begin
                        fresh_q[gi] <= 1'b0;
                    end else if (wr_hit[gi]) begin
                        fresh_q[gi] <= 1'b1;
                    end
                end
            end

            // Strobe window for this channel, based on the post-tick position.
            always_comb begin
                smp_d[gi] = !idle_d && (ch_d == CH_W'(gi)) &&
                            (bit_d >= BIT_W'(SMP_ON)) && (bit_d < BIT_W'(SMP_OFF));
            end
        end
    endgenerate

    // Select the word for the slot being loaded; a same-clk write bypasses the hold.
    always_comb begin
        load_word  = '0;
        load_fresh = 1'b0;
        load_wr    = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_d == CH_W'(c)) begin
                load_word  = hold_q[c];
                load_fresh = fresh_q[c];
                load_wr    = wr_hit[c];
            end
        end
        if (load_wr) begin
            load_word = host.sample_data;
        end
        load_stale = load && !load_fresh && !load_wr;
    end

    // Stream registers, bit clock, strobes and underrun accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            ch_q    <= '0;
            idle_q  <= 1'b1;
            shift_q <= '0;
            dclk_q  <= 1'b0;
            smp_q   <= '0;
            frame_q <= 1'b0;
            under_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ready_q <= 1'b1;
            div_q   <= div_d;
            bit_q   <= bit_d;
            ch_q    <= ch_d;
            idle_q  <= idle_d;
            dclk_q  <= en && (div_d >= DIV_W'(CLK_DIV / 2));
            frame_q <= load && (ch_d == '0);
            if (!en) begin
                shift_q <= '0;
                smp_q   <= '0;
            end else if (tick) begin
                shift_q <= load ? load_word : {shift_q[SAMPLE_W-2:0], 1'b0};
                smp_q   <= smp_d;
            end
            if (load_stale) begin
                under_q <= 1'b1;
                if (cnt_q != 8'hFF) begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

    assign host.sample_ready = ready_q;
    assign ym_dclk           = dclk_q;
    assign ym_smp            = smp_q;
    assign ym_data           = shift_q[SAMPLE_W-1];
    assign frame_start       = frame_q;
    assign underrun          = under_q;
    assign underrun_cnt      = cnt_q;
endmodule

// File: tb/tb_ym_dac_stream_gen.sv
// Bench for ym_dac_stream_gen: a frame-arithmetic reference model checks every
// clk of the default instance; tables and hand sequences cover the corner cases;
// a second instance covers a 4-channel/16-bit configuration.
module tb_ym_dac_stream_gen;
    localparam int CLK_DIV = 8;
    localparam int CH      = 2;
    localparam int SW      = 18;
    localparam int SL      = 18;
    localparam int SON     = 8;
    localparam int SOFF    = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b1;
    logic          en    = 1'b0;
    logic          en2   = 1'b0;
    logic          ym_dclk, ym_data, frame_start, underrun;
    logic [CH-1:0] ym_smp;
    logic [7:0]    underrun_cnt;
    logic          ym_dclk2, ym_data2, frame_start2, underrun2;
    logic [3:0]    ym_smp2;
    logic [7:0]    underrun_cnt2;

    ym_dac_stream_gen_if #(.SAMPLE_W(SW)) hif ();
    ym_dac_stream_gen_if #(.SAMPLE_W(16)) hif2 ();

    ym_dac_stream_gen dut (
        .clk(clk), .rst_n(rst_n), .en(en), .host(hif),
        .ym_dclk(ym_dclk), .ym_smp(ym_smp), .ym_data(ym_data),
        .frame_start(frame_start), .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    ym_dac_stream_gen #(
        .CLK_DIV(4), .CHANNELS(4), .SAMPLE_W(16), .SLOT_LEN(20), .SMP_ON(8), .SMP_OFF(16)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .host(hif2),
        .ym_dclk(ym_dclk2), .ym_smp(ym_smp2), .ym_data(ym_data2),
        .frame_start(frame_start2), .underrun(underrun2), .underrun_cnt(underrun_cnt2)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model (frame arithmetic) ----------------
    int            m_e     = 0;     // clk edges since en was sampled high
    bit            m_act   = 1'b0;
    bit            m_rdy   = 1'b0;
    logic [SW-1:0] m_hold [CH];
    bit            m_fresh [CH];
    bit            m_flag  = 1'b0;
    int            m_cnt   = 0;
    logic [SW-1:0] m_word  = '0;

    always @(posedge clk or negedge rst_n) begin
        bit wr, ld;
        int c, s, wch;
        if (!rst_n) begin
            m_e = 0; m_act = 0; m_rdy = 0; m_flag = 0; m_cnt = 0; m_word = '0;
            for (int i = 0; i < CH; i++) begin
                m_hold[i] = '0;
                m_fresh[i] = 0;
            end
        end else begin
            wch = int'(hif.sample_ch);
            wr  = hif.sample_valid && m_rdy && (wch < CH);
            ld  = 0;
            c   = 0;
            if (!en) begin
                m_act = 0;
                m_e   = 0;
            end else begin
                m_act = 1;
                m_e++;
                if (m_e % CLK_DIV == 0) begin
                    s = m_e / CLK_DIV - 1;
                    if (s % SL == 0) begin
                        ld = 1;
                        c  = (s / SL) % CH;
                    end
                end
                if (ld) begin
                    if (wr && wch == c) begin
                        m_word = hif.sample_data;
                    end else begin
                        m_word = m_hold[c];
                        if (!m_fresh[c]) begin
                            m_flag = 1;
                            if (m_cnt < 255) m_cnt++;
                        end
                    end
                    m_fresh[c] = 0;
                end
            end
            if (wr) begin
                m_hold[wch] = hif.sample_data;
                if (!(ld && wch == c)) m_fresh[wch] = 1;
            end
            m_rdy = 1;
        end
    end

    // Compare every output of the default instance one time unit after each edge.
    always @(posedge clk) begin
        logic [14:0]   exp_v, got_v;
        logic [CH-1:0] sm;
        logic          dk, d, fr;
        int            m, s, b, c;
        if (chk_on) begin
            #1;
            dk = 0; d = 0; sm = '0; fr = 0;
            if (m_act) begin
                dk = (m_e % CLK_DIV) >= CLK_DIV / 2;
                m  = m_e / CLK_DIV;
                if (m >= 1) begin
                    s = m - 1;
                    b = s % SL;
                    c = (s / SL) % CH;
                    if (b < SW) d = m_word[SW-1-b];
                    if (b >= SON && b < SOFF) sm[c] = 1'b1;
                    fr = (m_e % CLK_DIV == 0) && (b == 0) && (c == 0);
                end
            end
            exp_v = {m_rdy, dk, sm, d, fr, m_flag, 8'(m_cnt)};
            got_v = {hif.sample_ready, ym_dclk, ym_smp, ym_data, frame_start, underrun, underrun_cnt};
            check("stream", 128'(got_v), 128'(exp_v));
        end
    end

    // ---------------- helpers ----------------
    task automatic wr(input int ch, input logic [SW-1:0] d);
        @(negedge clk);
        hif.sample_valid = 1'b1;
        hif.sample_ch    = 3'(ch);
        hif.sample_data  = d;
        @(negedge clk);
        hif.sample_valid = 1'b0;
    endtask

    task automatic wr2(input int ch, input logic [15:0] d);
        @(negedge clk);
        hif2.sample_valid = 1'b1;
        hif2.sample_ch    = 3'(ch);
        hif2.sample_data  = d;
        @(negedge clk);
        hif2.sample_valid = 1'b0;
    endtask

    task automatic wait_frame(input bit which, output int at);
        bit seen;
        seen = 0;
        at   = 0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            @(posedge clk);
            #1;
            if ((which ? frame_start2 : frame_start) === 1'b1) begin
                seen = 1;
                at   = cyc;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL frame_wait: no frame_start within 1000 clk (instance %0d)", which);
        end
    endtask

    // Sample data at each ym_dclk rising edge, MSB first into bits[0] upward shift.
    task automatic capture(input bit which, input int n, output logic [127:0] bits);
        logic prev, cur;
        int   got;
        bits = '0;
        got  = 0;
        prev = which ? ym_dclk2 : ym_dclk;
        for (int k = 0; k < 4000 && got < n; k++) begin
            @(posedge clk);
            #1;
            cur = which ? ym_dclk2 : ym_dclk;
            if (!prev && cur) begin
                bits = {bits[126:0], (which ? ym_data2 : ym_data)};
                got++;
            end
            prev = cur;
        end
        if (got < n) begin
            checks++;
            errors++;
            $display("FAIL capture: got %0d of %0d bits", got, n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int            ch;
        logic [SW-1:0] data;
        logic [SW-1:0] exp_bits;
    } vec_t;

    vec_t          tbl [5];
    logic [127:0]  bits;
    logic [17:0]   slot;
    int            t0, t1, c0;
    logic [7:0]    cnt_before;

    initial begin
        tbl[0] = '{0, 18'h3C2A8, 18'b111100001010101000};
        tbl[1] = '{1, 18'h00001, 18'b000000000000000001};
        tbl[2] = '{0, 18'h2AAAA, 18'b101010101010101010};
        tbl[3] = '{1, 18'h3FFFF, 18'b111111111111111111};
        tbl[4] = '{0, 18'h20000, 18'b100000000000000000};

        hif.sample_valid  = 1'b0; hif.sample_ch  = '0; hif.sample_data  = '0;
        hif2.sample_valid = 1'b0; hif2.sample_ch = '0; hif2.sample_data = '0;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              128'({hif.sample_ready, ym_dclk, ym_smp, ym_data, frame_start, underrun, underrun_cnt}), 128'(0));
        chk_on = 1'b1;
        rst_n  = 1'b1;
        check("ready_at_release", 128'(hif.sample_ready), 128'(0));
        @(posedge clk); #1;
        check("ready_after_1clk", 128'(hif.sample_ready), 128'(1));

        // Both channels written before the first tick: clean first frame.
        wr(0, 18'h3C2A8);
        wr(1, 18'h3C2A8);
        @(negedge clk); en = 1'b1;
        wait_frame(0, t0);
        capture(0, 36, bits);
        check("frame1_serial", 128'(bits[35:0]), 128'({2{18'b111100001010101000}}));
        check("frame1_no_underrun", 128'(underrun), 128'(0));
        wait_frame(0, t1);
        check("frame_period", 128'(t1 - t0), 128'(288));

        // Table: write a channel, then capture that channel's slot in the next frame.
        foreach (tbl[i]) begin
            wait_frame(0, t0);
            wr(tbl[i].ch, tbl[i].data);
            wait_frame(0, t1);
            capture(0, 36, bits);
            slot = (tbl[i].ch == 0) ? bits[35:18] : bits[17:0];
            check($sformatf("table%0d_ch%0d", i, tbl[i].ch), 128'(slot), 128'(tbl[i].exp_bits));
        end

        // Write on the exact clk of the ch0 load: bypass, no underrun counted.
        wait_frame(0, t0);
        repeat (288) @(negedge clk);
        cnt_before = underrun_cnt;
        hif.sample_valid = 1'b1; hif.sample_ch = 3'd0; hif.sample_data = 18'h00001;
        @(negedge clk);
        hif.sample_valid = 1'b0;
        capture(0, 18, bits);
        check("bypass_serial", 128'(bits[17:0]), 128'(18'h00001));
        check("bypass_no_underrun", 128'(underrun_cnt), 128'(cnt_before));

        // Only ch0 written: each following load is stale.
        @(negedge clk); en = 1'b0;
        do_reset();
        wr(0, 18'h12345);
        @(negedge clk); en = 1'b1;
        wait_frame(0, t0);
        check("ur_cnt_frame1", 128'(underrun_cnt), 128'(0));
        for (int k = 1; k <= 3; k++) begin
            repeat (144) @(posedge clk); #1;
            check($sformatf("ur_cnt_load%0d", k), 128'({underrun, underrun_cnt}), 128'({1'b1, 8'(k)}));
        end

        // Asynchronous reset in the middle of slot 1.
        wait_frame(0, t0);
        repeat (150) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset",
              128'({hif.sample_ready, ym_dclk, ym_smp, ym_data, frame_start, underrun, underrun_cnt}), 128'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        c0 = cyc;
        check("ready_low_at_release", 128'(hif.sample_ready), 128'(0));
        @(posedge clk); #1;
        check("ready_high_after_release", 128'(hif.sample_ready), 128'(1));
        wait_frame(0, t1);
        check("restart_latency", 128'(t1 - c0), 128'(CLK_DIV));

        // Random writes (including ignored channels) and occasional en toggles.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            hif.sample_valid = ($urandom_range(0, 3) == 0);
            hif.sample_ch    = 3'($urandom_range(0, 3));
            hif.sample_data  = SW'($urandom);
            if ($urandom_range(0, 599) == 0) en = ~en;
        end
        @(negedge clk);
        hif.sample_valid = 1'b0;
        en = 1'b1;
        repeat (300) @(posedge clk);

        // 4-channel, 16-bit, 20-bit-slot instance.
        wr2(0, 16'hA5A5);
        wr2(1, 16'h0001);
        wr2(2, 16'h8000);
        wr2(3, 16'hFFFF);
        @(negedge clk); en2 = 1'b1;
        wait_frame(1, t0);
        capture(1, 80, bits);
        check("ch4_serial", 128'(bits[79:0]),
              128'({16'hA5A5, 4'h0, 16'h0001, 4'h0, 16'h8000, 4'h0, 16'hFFFF, 4'h0}));
        check("ch4_no_underrun", 128'({underrun2, underrun_cnt2}), 128'(0));
        wait_frame(1, t1);
        check("ch4_period", 128'(t1 - t0), 128'(320));
        check("ch4_smp_idle_at_load", 128'(ym_smp2), 128'(0));

        chk_on = 1'b0;
        @(posedge clk); #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ym_dac_stream_gen.md
Name: ym_dac_stream_gen

Overview:
- Parametrised, synthesizable generator of a YMF262-style serial DAC stream: bit clock (ym_dclk), per-channel sample strobes (ym_smp) and MSB-first serial data (ym_data).
- Successor to the fixed 2-channel/18-bit bench model. Channel count, sample width, slot length, strobe window and clock divide are configurable.
- Sample words arrive from the host through a valid/ready port, are double-buffered per channel, and are checked for underrun.
- Used as the OPL3 stand-in in CPLD benches and as the pattern source for the board-test build.

Parameters:
- CLK_DIV, 8, clk cycles per ym_dclk period; even, >=2.
- CHANNELS, 2, number of time-multiplexed channels; 1..8.
- SAMPLE_W, 18, bits per sample word.
- SLOT_LEN, 18, ym_dclk periods per channel slot; >=SAMPLE_W.
- SMP_ON, 8, slot bit index where ym_smp[ch] rises.
- SMP_OFF, 16, slot bit index where ym_smp[ch] falls; SMP_ON<SMP_OFF<=SLOT_LEN.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, stream enable.
- sample_valid, in, 1, host sample write strobe.
- sample_ch, in, 3, target channel; values >=CHANNELS are accepted and ignored.
- sample_data, in, SAMPLE_W, sample word.
- sample_ready, out, 1, write accepted when high.
- ym_dclk, out, 1, serial bit clock.
- ym_smp, out, CHANNELS, per-channel sample strobe.
- ym_data, out, 1, serial data, MSB first.
- frame_start, out, 1, one-clk pulse at the start of channel 0 bit 0.
- underrun, out, 1, sticky flag; set when any slot starts with a stale sample.
- underrun_cnt, out, 8, saturating count of underruns.

Behaviour:
- Reset (rst_n low, async): all internal state clears.
  - Outputs: ym_dclk=0, ym_smp=0, ym_data=0, frame_start=0, underrun=0, underrun_cnt=0, sample_ready=0.
  - Internal: div_cnt=0, bit_cnt=0, ch_cnt=0, shift=0, all hold[ch]=0, all fresh[ch]=0.
  - The first clk after release sets sample_ready=1. sample_ready stays 1 until the next reset.
- Divider:
  - div_cnt runs 0..CLK_DIV-1 while en=1.
  - ym_dclk is registered: high for div_cnt in [CLK_DIV/2, CLK_DIV-1], low otherwise.
  - tick = en && div_cnt==CLK_DIV-1.
  - All stream state updates on tick, i.e. at the ym_dclk falling edge, so ym_data and ym_smp are stable at the next rising edge.
- Slot/channel counters:
  - On tick, bit_cnt increments.
  - When bit_cnt reaches SLOT_LEN-1 it wraps to 0 and ch_cnt advances.
  - ch_cnt wraps CHANNELS-1 -> 0.
  - Frame length is SLOT_LEN*CHANNELS dclk periods (36 dclk = 288 clk at defaults).
- Load: on a tick entering bit_cnt=0 for channel c:
  - shift <= hold[c] and fresh[c] <= 0.
  - If fresh[c] was 0, set underrun=1 and increment underrun_cnt (saturates at 255). The stale hold[c] is replayed.
  - If c==0, frame_start pulses for one clk, coincident with the load.
- Shift:
  - On other ticks, shift <= {shift[SAMPLE_W-2:0],0}.
  - ym_data = shift[SAMPLE_W-1].
  - Bits SAMPLE_W..SLOT_LEN-1 of a slot are therefore 0.
- Strobe: ym_smp[c] = (ch_cnt==c) && SMP_ON<=bit_cnt<SMP_OFF, registered and updated on tick. Only one strobe bit is high at a time.
- Host write:
  - Accepted when sample_valid && sample_ready.
  - Sets hold[sample_ch]=sample_data and fresh[sample_ch]=1. A second write before the load overwrites silently.
  - Write to channel c on the same clk as the load of c: the load takes sample_data directly (bypass), fresh[c] ends 0, and no underrun is counted.
- Underrun clear: underrun and underrun_cnt clear only on reset. Reading them has no effect.
- en=0:
  - Synchronously returns div_cnt, bit_cnt and ch_cnt to 0.
  - Forces ym_dclk=0, ym_smp=0 and shift=0.
  - hold, fresh and underrun state are retained, and host writes are still accepted.
  - When en rises, the first tick loads channel 0 (frame_start pulses).
- Reset mid-frame forces all outputs to their reset values immediately, independent of clk.

Test Plan:
- Defaults, en=1; write 0x3C2A8 to ch0 and ch1 before the first tick -> ym_data per slot = 111100001010101000 MSB first; frame_start every 288 clk; underrun stays 0 for the first frame.
- Defaults; after each ym_smp[0] pulse, observe ym_smp -> ym_smp[0] high for dclk bits 8..15 of slot 0, ym_smp[1] high for bits 8..15 of slot 1 (frame bits 26..33); never both high.
- Write ch0 only, then let 2 frames elapse -> underrun=1 at the first ch1 load; underrun_cnt=1,2,3 after successive stale loads; ch1 replays its hold value.
- Write 0x00001 to ch0 on the exact clk of the ch0 load -> slot transmits 0x00001 (LSB on bit 17); underrun_cnt unchanged.
- Assert rst_n low mid-slot 1 for 3 clk -> ym_dclk, ym_smp, ym_data and underrun all 0 asynchronously; after release, sample_ready=1 one clk later and the stream restarts at ch0 bit0.
- CHANNELS=4, SAMPLE_W=16, SLOT_LEN=20, CLK_DIV=4; write 0xA5A5/0x0001/0x8000/0xFFFF -> four slots in order with 4 zero pad bits each; frame_start every 320 clk.
